// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch stage: PC register, IF/ID pipeline register and
//            IDLE/RUN/HALT control with stall, flush, redirect and halt detect.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
   input  logic        CLK,
   input  logic        rst,
   input  logic        stall_if,
   input  logic        flush_if,
   input  logic        pc_src,
   input  logic [31:0] branch_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc4,
   output logic [31:0] ifid_instr,
   output logic        ifid_valid,
   output logic [15:0] fetch_count,
   output logic        halted
);

   localparam logic [15:0] c_COUNT_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_pc4_q, ifid_pc4_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [15:0] fetch_count_q, fetch_count_d;

   logic [31:0] w_pc_plus4;
   logic        w_capture;

   // Natural 32-bit overflow gives the required wrap to zero.
   assign w_pc_plus4 = pc_q + 32'd4;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      ifid_pc_d     = ifid_pc_q;
      ifid_pc4_d    = ifid_pc4_q;
      ifid_instr_d  = ifid_instr_q;
      ifid_valid_d  = ifid_valid_q;
      fetch_count_d = fetch_count_q;
      w_capture     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            pc_d    = RESET_PC;
            state_d = ST_RUN;
         end

         ST_RUN: begin
            if (flush_if) begin
               ifid_pc_d    = 32'h0;
               ifid_pc4_d   = 32'h0;
               ifid_instr_d = 32'h0;
               ifid_valid_d = 1'b0;
            end else if (!stall_if) begin
               w_capture    = 1'b1;
               ifid_pc_d    = pc_q;
               ifid_pc4_d   = w_pc_plus4;
               ifid_instr_d = imem_rdata;
               ifid_valid_d = 1'b1;
            end

            // Redirect wins over a stall so a resolved branch is never lost.
            if (pc_src) begin
               pc_d = branch_target;
            end else if (!stall_if) begin
               pc_d = w_pc_plus4;
            end

            if (w_capture && (fetch_count_q != c_COUNT_MAX)) begin
               fetch_count_d = fetch_count_q + 16'd1;
            end

            if (w_capture && (imem_rdata[31:26] == HALT_OPCODE)) begin
               state_d = ST_HALT;
            end
         end

         ST_HALT: begin
            ifid_pc_d    = 32'h0;
            ifid_pc4_d   = 32'h0;
            ifid_instr_d = 32'h0;
            ifid_valid_d = 1'b0;
            // A redirect means the halt was speculative; resume fetching.
            if (pc_src) begin
               pc_d    = branch_target;
               state_d = ST_RUN;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         ifid_pc_q     <= 32'h0;
         ifid_pc4_q    <= 32'h0;
         ifid_instr_q  <= 32'h0;
         ifid_valid_q  <= 1'b0;
         fetch_count_q <= 16'h0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         ifid_pc_q     <= ifid_pc_d;
         ifid_pc4_q    <= ifid_pc4_d;
         ifid_instr_q  <= ifid_instr_d;
         ifid_valid_q  <= ifid_valid_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign imem_addr   = pc_q;
   assign ifid_pc     = ifid_pc_q;
   assign ifid_pc4    = ifid_pc4_q;
   assign ifid_instr  = ifid_instr_q;
   assign ifid_valid  = ifid_valid_q;
   assign fetch_count = fetch_count_q;
   assign halted      = (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage: directed scenarios plus random
//            stall/flush/redirect/reset traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [5:0]  HALT_OP  = 6'h3F;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;

   logic        CLK = 1'b0;
   logic        rst = 1'b1;
   logic        stall_if = 1'b0;
   logic        flush_if = 1'b0;
   logic        pc_src = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc4;
   logic [31:0] ifid_instr;
   logic        ifid_valid;
   logic [15:0] fetch_count;
   logic        halted;

   logic [31:0] imem_tbl [0:63];

   int n_chk = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   // Behavioural model of the stage as seen from the outside
   int          m_mode;
   logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
   logic        m_valid;
   logic [15:0] m_cnt;

   if_stage #(
      .RESET_PC   (RESET_PC),
      .HALT_OPCODE(HALT_OP)
   ) dut (
      .CLK          (CLK),
      .rst          (rst),
      .stall_if     (stall_if),
      .flush_if     (flush_if),
      .pc_src       (pc_src),
      .branch_target(branch_target),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .ifid_pc      (ifid_pc),
      .ifid_pc4     (ifid_pc4),
      .ifid_instr   (ifid_instr),
      .ifid_valid   (ifid_valid),
      .fetch_count  (fetch_count),
      .halted       (halted)
   );

   always #5 CLK = ~CLK;

   // Small memory aliased over the whole address space
   always_comb imem_rdata = imem_tbl[imem_addr[7:2]];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_pc    = RESET_PC;
      m_ipc   = 32'h0;
      m_ipc4  = 32'h0;
      m_instr = 32'h0;
      m_valid = 1'b0;
      m_cnt   = 16'h0;
   endtask

   // One clock cycle: drive inputs mid-low-phase, predict, then commit at the edge.
   task automatic cycle(input logic s, input logic f, input logic p, input logic [31:0] t);
      logic [31:0] w, npc, nipc, nipc4, ninstr;
      logic        nvalid;
      logic [15:0] ncnt;
      int          nmode;
      @(negedge CLK);
      #2;
      stall_if      = s;
      flush_if      = f;
      pc_src        = p;
      branch_target = t;
      w      = imem_tbl[m_pc[7:2]];
      npc    = m_pc;
      nipc   = m_ipc;
      nipc4  = m_ipc4;
      ninstr = m_instr;
      nvalid = m_valid;
      ncnt   = m_cnt;
      nmode  = m_mode;
      if (m_mode == M_IDLE) begin
         nmode = M_RUN;
      end else if (m_mode == M_RUN) begin
         if (f) begin
            {nipc, nipc4, ninstr, nvalid} = '0;
         end else if (!s) begin
            nipc   = m_pc;
            nipc4  = m_pc + 32'd4;
            ninstr = w;
            nvalid = 1'b1;
            if (m_cnt != 16'hFFFF) ncnt = m_cnt + 16'd1;
            if (w[31:26] == HALT_OP) nmode = M_HALT;
         end
         npc = p ? t : (s ? m_pc : m_pc + 32'd4);
      end else begin
         {nipc, nipc4, ninstr, nvalid} = '0;
         if (p) begin
            npc   = t;
            nmode = M_RUN;
         end
      end
      @(posedge CLK);
      m_pc    = npc;
      m_ipc   = nipc;
      m_ipc4  = nipc4;
      m_instr = ninstr;
      m_valid = nvalid;
      m_cnt   = ncnt;
      m_mode  = nmode;
      #1;
   endtask

   // Assert reset between edges and confirm it acts without a clock.
   task automatic async_reset();
      @(negedge CLK);
      #3;
      rst = 1'b0;
      model_reset();
      #1;
      chk("arst_imem_addr", imem_addr, RESET_PC);
      chk("arst_ifid_pc", ifid_pc, 32'h0);
      chk("arst_ifid_pc4", ifid_pc4, 32'h0);
      chk("arst_ifid_instr", ifid_instr, 32'h0);
      chk("arst_valid", {31'h0, ifid_valid}, 32'h0);
      chk("arst_count", {16'h0, fetch_count}, 32'h0);
      chk("arst_halted", {31'h0, halted}, 32'h0);
      @(posedge CLK);
      #1;
      rst = 1'b1;
   endtask

   always @(negedge CLK) begin
      if (chk_on) begin
         chk("imem_addr", imem_addr, m_pc);
         chk("ifid_pc", ifid_pc, m_ipc);
         chk("ifid_pc4", ifid_pc4, m_ipc4);
         chk("ifid_instr", ifid_instr, m_instr);
         chk("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_valid});
         chk("fetch_count", {16'h0, fetch_count}, {16'h0, m_cnt});
         chk("halted", {31'h0, halted}, {31'h0, (m_mode == M_HALT)});
      end
   end

   initial begin
      logic [31:0] r, t;
      for (int i = 0; i < 64; i++) imem_tbl[i] = 32'h2000_0000 | i;
      imem_tbl[0] = 32'h2001_0005;
      imem_tbl[1] = 32'h2002_0007;
      imem_tbl[4] = 32'hFC00_0000;

      #1;
      rst = 1'b0;
      model_reset();
      #1;
      chk("rst_imem_addr", imem_addr, RESET_PC);
      chk("rst_valid", {31'h0, ifid_valid}, 32'h0);
      chk("rst_count", {16'h0, fetch_count}, 32'h0);
      chk("rst_halted", {31'h0, halted}, 32'h0);
      @(posedge CLK);
      #1;
      rst    = 1'b1;
      chk_on = 1'b1;

      // Reset, then two sequential captures
      cycle(0, 0, 0, 32'h0);
      chk("idle_no_capture", {31'h0, ifid_valid}, 32'h0);
      chk("idle_pc", imem_addr, 32'h0);
      cycle(0, 0, 0, 32'h0);
      chk("cap0_pc", ifid_pc, 32'h0);
      chk("cap0_instr", ifid_instr, 32'h2001_0005);
      chk("cap0_valid", {31'h0, ifid_valid}, 32'h1);
      cycle(0, 0, 0, 32'h0);
      chk("cap1_pc", ifid_pc, 32'h4);
      chk("cap1_pc4", ifid_pc4, 32'h8);
      chk("cap1_count", {16'h0, fetch_count}, 32'd2);

      // Two-cycle stall at PC 0x8
      for (int k = 0; k < 2; k++) begin
         cycle(1, 0, 0, 32'h0);
         chk("stall_addr", imem_addr, 32'h8);
         chk("stall_ifid_pc", ifid_pc, 32'h4);
         chk("stall_count", {16'h0, fetch_count}, 32'd2);
      end
      cycle(0, 0, 0, 32'h0);
      chk("post_stall_pc", ifid_pc, 32'h8);
      chk("post_stall_addr", imem_addr, 32'hC);

      // Redirect + flush + stall all together at PC 0xC
      cycle(1, 1, 1, 32'h40);
      chk("redir_addr", imem_addr, 32'h40);
      chk("redir_valid", {31'h0, ifid_valid}, 32'h0);
      chk("redir_instr", ifid_instr, 32'h0);

      // Reach 0x10 and fetch the halt word
      cycle(0, 0, 1, 32'h10);
      cycle(0, 0, 0, 32'h0);
      chk("halt_instr", ifid_instr, 32'hFC00_0000);
      chk("halt_valid", {31'h0, ifid_valid}, 32'h1);
      chk("halt_flag", {31'h0, halted}, 32'h1);
      cycle(1, 0, 0, 32'h0);
      chk("halt_bubble", {31'h0, ifid_valid}, 32'h0);
      chk("halt_pc_frozen", imem_addr, 32'h14);
      chk("halt_count", {16'h0, fetch_count}, 32'd5);
      cycle(0, 0, 1, 32'h20);
      chk("unhalt_flag", {31'h0, halted}, 32'h0);
      chk("unhalt_addr", imem_addr, 32'h20);
      cycle(0, 0, 0, 32'h0);
      chk("unhalt_cap_pc", ifid_pc, 32'h20);

      // Wrap at the top of the address space, then async reset
      cycle(0, 0, 1, 32'hFFFF_FFFC);
      cycle(0, 0, 0, 32'h0);
      chk("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
      chk("wrap_pc4", ifid_pc4, 32'h0);
      chk("wrap_addr", imem_addr, 32'h0);
      async_reset();
      cycle(0, 0, 0, 32'h0);
      chk("rearm_idle", {31'h0, ifid_valid}, 32'h0);
      cycle(0, 0, 0, 32'h0);
      chk("rearm_cap", {31'h0, ifid_valid}, 32'h1);
      chk("rearm_count", {16'h0, fetch_count}, 32'd1);

      // Random traffic with sprinkled halt words and resets
      for (int i = 0; i < 64; i++) begin
         r = $urandom;
         if ($urandom_range(0, 7) == 0) imem_tbl[i] = {HALT_OP, r[25:0]};
         else imem_tbl[i] = {6'($urandom_range(0, 62)), r[25:0]};
      end
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 299) == 0) begin
            async_reset();
         end else begin
            r = $urandom;
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | (r & 32'hC)) : (r & ~32'h3);
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0, t);
         end
      end

      @(negedge CLK);
      #1;
      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
